// File: rtl/payload_pkg.sv
// Shared constants and state encoding for the payload assembler.
// Imported by the assembler and its word buffer.
package payload_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int         MAX_WORDS = 4;
  localparam int         CNT_W     = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_PAYLOAD,
    S_CHECK,
    S_EMIT
  } state_t;

endpackage

// File: rtl/pkt_word_buf.sv
// Payload word store: big-endian byte packing on write,
// sequential word readout with its own read index.
module pkt_word_buf #(
  parameter int MAX_WORDS = 4,
  parameter int WW        = 3,
  parameter int BW        = WW + 2
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          clear,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  input  logic          rd_en,
  output logic [BW-1:0] wr_idx,
  output logic [WW-1:0] rd_idx,
  output logic [31:0]   rd_word
);

  logic [31:0] mem [MAX_WORDS];

  logic [WW-1:0] wsel;
  assign wsel    = wr_idx[BW-1:2];
  assign rd_word = mem[rd_idx];

  // Byte and word indices restart for every new packet
  always_ff @(posedge CLK) begin
    if (RESET || clear) begin
      wr_idx <= '0;
      rd_idx <= '0;
    end else begin
      if (wr_en) wr_idx <= wr_idx + BW'(1);
      if (rd_en) rd_idx <= rd_idx + WW'(1);
    end
  end

  // First byte of each word lands in the top lane
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      unique case (wr_idx[1:0])
        2'd0: mem[wsel][31:24] <= wr_data;
        2'd1: mem[wsel][23:16] <= wr_data;
        2'd2: mem[wsel][15:8]  <= wr_data;
        2'd3: mem[wsel][7:0]   <= wr_data;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/payload_assembler.sv
// Packet parser: sync/length/payload/checksum framing,
// then emits the buffered payload one word per cycle.
module payload_assembler #(
  parameter logic [7:0] SYNC_BYTE = payload_pkg::SYNC_BYTE,
  parameter int         MAX_WORDS = payload_pkg::MAX_WORDS
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        RX_VALID,
  input  logic [7:0]  RX_DATA,
  input  logic        RX_SOF,
  input  logic        RX_EOF,
  output logic        RX_READY,
  output logic        PACKET_READY,
  output logic [31:0] PAYLOAD_DATA,
  output logic        PKT_ERROR,
  output logic [payload_pkg::CNT_W-1:0] PKT_COUNT
);

  import payload_pkg::*;

  localparam int WW = $clog2(MAX_WORDS + 1);
  localparam int BW = WW + 2;

  state_t        state;
  logic [7:0]    csum;
  logic [WW-1:0] n_words;

  logic          acc;
  logic          sync_hit;
  logic          len_ok;
  logic          last_byte;
  logic          sum_ok;
  logic          buf_clr;
  logic          buf_wr;
  logic          buf_rd;
  logic [BW-1:0] wr_idx;
  logic [WW-1:0] rd_idx;
  logic [31:0]   rd_word;

  assign RX_READY  = (state != S_EMIT);
  assign acc       = RX_VALID && RX_READY;
  assign sync_hit  = RX_SOF && (RX_DATA == SYNC_BYTE);
  assign len_ok    = (RX_DATA != 8'd0) &&
                     (RX_DATA <= 8'(MAX_WORDS));
  assign last_byte = (wr_idx + BW'(1)) == {n_words, 2'b00};
  assign sum_ok    = RX_EOF && (RX_DATA == csum);

  // Buffer strobes decoded from the current state and byte
  always_comb begin
    buf_clr = 1'b0;
    buf_wr  = 1'b0;
    buf_rd  = 1'b0;
    unique case (state)
      S_LEN:
        buf_clr = acc && !RX_SOF && !RX_EOF && len_ok;
      S_PAYLOAD:
        buf_wr = acc && !RX_SOF && !RX_EOF;
      S_CHECK:
        buf_rd = acc && !RX_SOF && sum_ok;
      S_EMIT:
        buf_rd = (rd_idx != n_words);
      default: ;
    endcase
  end

  pkt_word_buf #(
    .MAX_WORDS (MAX_WORDS),
    .WW        (WW),
    .BW        (BW)
  ) u_buf (
    .CLK     (CLK),
    .RESET   (RESET),
    .clear   (buf_clr),
    .wr_en   (buf_wr),
    .wr_data (RX_DATA),
    .rd_en   (buf_rd),
    .wr_idx  (wr_idx),
    .rd_idx  (rd_idx),
    .rd_word (rd_word)
  );

  // Framing FSM with registered outputs; an SOF inside a packet
  // aborts it and is reparsed as a fresh sync byte
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state        <= S_IDLE;
      csum         <= '0;
      n_words      <= '0;
      PACKET_READY <= 1'b0;
      PAYLOAD_DATA <= '0;
      PKT_ERROR    <= 1'b0;
      PKT_COUNT    <= '0;
    end else begin
      PKT_ERROR    <= 1'b0;
      PACKET_READY <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (acc && sync_hit) state <= S_LEN;
        end
        S_LEN: begin
          if (acc) begin
            if (RX_SOF) begin
              PKT_ERROR <= 1'b1;
              state     <= sync_hit ? S_LEN : S_IDLE;
            end else if (RX_EOF || !len_ok) begin
              PKT_ERROR <= 1'b1;
              state     <= S_IDLE;
            end else begin
              n_words <= RX_DATA[WW-1:0];
              csum    <= '0;
              state   <= S_PAYLOAD;
            end
          end
        end
        S_PAYLOAD: begin
          if (acc) begin
            if (RX_SOF) begin
              PKT_ERROR <= 1'b1;
              state     <= sync_hit ? S_LEN : S_IDLE;
            end else if (RX_EOF) begin
              PKT_ERROR <= 1'b1;
              state     <= S_IDLE;
            end else begin
              csum <= csum ^ RX_DATA;
              if (last_byte) state <= S_CHECK;
            end
          end
        end
        S_CHECK: begin
          if (acc) begin
            if (RX_SOF) begin
              PKT_ERROR <= 1'b1;
              state     <= sync_hit ? S_LEN : S_IDLE;
            end else if (sum_ok) begin
              PACKET_READY <= 1'b1;
              PAYLOAD_DATA <= rd_word;
              state        <= S_EMIT;
            end else begin
              PKT_ERROR <= 1'b1;
              state     <= S_IDLE;
            end
          end
        end
        S_EMIT: begin
          if (rd_idx == n_words) begin
            PKT_COUNT <= PKT_COUNT + 1'b1;
            state     <= S_IDLE;
          end else begin
            PACKET_READY <= 1'b1;
            PAYLOAD_DATA <= rd_word;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_payload_assembler.sv
// Scoreboard bench for payload_assembler: directed packets,
// expected words/errors queued and checked by a monitor.
module tb_payload_assembler;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        RX_VALID = 1'b0;
  logic [7:0]  RX_DATA = 8'h00;
  logic        RX_SOF = 1'b0;
  logic        RX_EOF = 1'b0;
  logic        RX_READY;
  logic        PACKET_READY;
  logic [31:0] PAYLOAD_DATA;
  logic        PKT_ERROR;
  logic [15:0] PKT_COUNT;

  payload_assembler dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .RX_VALID     (RX_VALID),
    .RX_DATA      (RX_DATA),
    .RX_SOF       (RX_SOF),
    .RX_EOF       (RX_EOF),
    .RX_READY     (RX_READY),
    .PACKET_READY (PACKET_READY),
    .PAYLOAD_DATA (PAYLOAD_DATA),
    .PKT_ERROR    (PKT_ERROR),
    .PKT_COUNT    (PKT_COUNT)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic        err;
    logic [31:0] w;
  } ev_t;

  ev_t        exp_q[$];
  logic [7:0] pkt[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         rdy_low = 0;

  function automatic void chk(input string nm,
                              input logic [31:0] act,
                              input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endfunction

  function automatic void exp_word(input logic [31:0] w);
    ev_t e;
    e.err = 1'b0;
    e.w   = w;
    exp_q.push_back(e);
  endfunction

  function automatic void exp_err();
    ev_t e;
    e.err = 1'b1;
    e.w   = '0;
    exp_q.push_back(e);
  endfunction

  // Monitor: every output event must match the queue head
  always @(negedge CLK) begin
    ev_t e;
    if (!RX_READY) rdy_low++;
    if (PACKET_READY && PKT_ERROR) begin
      n_cmp++;
      n_bad++;
      $display("FAIL both_high: PACKET_READY and PKT_ERROR at %0t",
               $time);
    end else if (PACKET_READY || PKT_ERROR) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_event: rdy=%b err=%b data=%h",
                 PACKET_READY, PKT_ERROR, PAYLOAD_DATA);
      end else begin
        e = exp_q.pop_front();
        chk("event_kind_err", 32'(PKT_ERROR), 32'(e.err));
        if (!e.err) chk("payload_word", PAYLOAD_DATA, e.w);
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input bit sof,
                      input bit eof, input int gap);
    int t;
    t = 0;
    RX_VALID = 1'b1;
    RX_DATA  = d;
    RX_SOF   = sof;
    RX_EOF   = eof;
    while (!RX_READY && t < 50) begin
      tick();
      t++;
    end
    if (!RX_READY) begin
      n_cmp++;
      n_bad++;
      $display("FAIL rx_ready_timeout: got 0, expected 1");
    end
    tick();
    RX_VALID = 1'b0;
    RX_SOF   = 1'b0;
    RX_EOF   = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic send_pkt(input int gap);
    for (int i = 0; i < pkt.size(); i++)
      send(pkt[i], i == 0, i == pkt.size() - 1, gap);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    RESET = 1'b1;
    repeat (2) tick();
    chk("reset_rx_ready", 32'(RX_READY), 32'd1);
    chk("reset_pkt_ready", 32'(PACKET_READY), 32'd0);
    chk("reset_payload", PAYLOAD_DATA, 32'h0);
    chk("reset_error", 32'(PKT_ERROR), 32'd0);
    chk("reset_count", 32'(PKT_COUNT), 32'd0);
    RESET = 1'b0;
    tick();

    // single-word packet, check first-word latency
    exp_word(32'h01020304);
    pkt = '{8'hA5, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
    send_pkt(0);
    chk("latency_pkt_ready", 32'(PACKET_READY), 32'd1);
    repeat (4) tick();
    chk("count_after_1", 32'(PKT_COUNT), 32'd1);

    // two-word packet with RX_VALID gaps
    exp_word(32'h11223344);
    exp_word(32'h55667788);
    pkt = '{8'hA5, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44,
            8'h55, 8'h66, 8'h77, 8'h88, 8'h88};
    rdy_low = 0;
    send_pkt(1);
    repeat (5) tick();
    chk("rx_ready_low_cycles", 32'(rdy_low), 32'd2);
    chk("count_after_2", 32'(PKT_COUNT), 32'd2);

    // bad checksum
    exp_err();
    pkt = '{8'hA5, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h00};
    send_pkt(0);
    repeat (3) tick();
    chk("count_bad_sum", 32'(PKT_COUNT), 32'd2);

    // illegal length, trailing bytes silently dropped
    exp_err();
    send(8'hA5, 1, 0, 0);
    send(8'h05, 0, 0, 0);
    chk("len_error_timing", 32'(PKT_ERROR), 32'd1);
    send(8'h11, 0, 0, 0);
    send(8'h22, 0, 0, 0);
    send(8'h33, 0, 0, 0);
    send(8'h44, 0, 1, 0);
    repeat (3) tick();
    chk("count_bad_len", 32'(PKT_COUNT), 32'd2);

    // EOF inside the payload
    exp_err();
    send(8'hA5, 1, 0, 0);
    send(8'h01, 0, 0, 0);
    send(8'h01, 0, 0, 0);
    send(8'h02, 0, 1, 0);
    repeat (3) tick();
    chk("count_early_eof", 32'(PKT_COUNT), 32'd2);

    // SOF mid-packet restarts parsing on that byte
    exp_err();
    exp_word(32'h01020304);
    send(8'hA5, 1, 0, 0);
    send(8'h02, 0, 0, 0);
    send(8'h11, 0, 0, 0);
    send(8'h22, 0, 0, 0);
    pkt = '{8'hA5, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
    send_pkt(0);
    repeat (4) tick();
    chk("count_sof_abort", 32'(PKT_COUNT), 32'd3);

    // reset during the second word of a two-word packet
    exp_word(32'h11223344);
    exp_word(32'h55667788);
    pkt = '{8'hA5, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44,
            8'h55, 8'h66, 8'h77, 8'h88, 8'h88};
    send_pkt(0);
    tick();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    chk("rst_emit_pkt_ready", 32'(PACKET_READY), 32'd0);
    chk("rst_emit_count", 32'(PKT_COUNT), 32'd0);
    chk("rst_emit_rx_ready", 32'(RX_READY), 32'd1);
    repeat (5) tick();
    chk("rst_emit_count_hold", 32'(PKT_COUNT), 32'd0);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
